// File: rtl/mem_copy_engine_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_engine_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Data memory bus: the engine is master, the memory array is slave.
interface mem_copy_engine_if
   import mem_copy_engine_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] write_value;
   logic [DATA_W-1:0] read_value;

   modport master (
      output mem_addr,
      output mem_read,
      output mem_write,
      output write_value,
      input  read_value
   );

   modport slave (
      input  mem_addr,
      input  mem_read,
      input  mem_write,
      input  write_value,
      output read_value
   );

endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial memory copy engine sharing the data memory with the core.
// In IDLE the core owns the bus; otherwise the engine alternates RD/WR.
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_read,
   input  logic              core_write,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_stall,
   mem_copy_engine_if.master mem
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;

   // State and datapath registers, cleared asynchronously by reset low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state, datapath updates and bus mux (core pass-through only in IDLE).
   always_comb begin
      state_d         = state_q;
      src_d           = src_q;
      dst_d           = dst_q;
      cnt_d           = cnt_q;
      buf_d           = buf_q;
      busy            = 1'b1;
      done            = 1'b0;
      mem.mem_addr    = '0;
      mem.mem_read    = 1'b0;
      mem.mem_write   = 1'b0;
      mem.write_value = buf_q;

      unique case (state_q)
         IDLE: begin
            busy            = 1'b0;
            mem.mem_addr    = core_addr;
            mem.mem_read    = core_read;
            mem.mem_write   = core_write;
            mem.write_value = core_wdata;
            if (start) begin
               if (len != '0) begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  cnt_d   = len;
                  state_d = RD;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD: begin
            mem.mem_addr = src_q;
            mem.mem_read = 1'b1;
            buf_d        = mem.read_value;
            state_d      = WR;
         end
         WR: begin
            mem.mem_addr  = dst_q;
            mem.mem_write = 1'b1;
            src_d         = src_q + ADDR_ONE;
            dst_d         = dst_q + ADDR_ONE;
            cnt_d         = cnt_q - ADDR_ONE;
            state_d       = (cnt_q == ADDR_ONE) ? DONE : RD;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign core_stall = busy;

endmodule
